// File: rtl/alu_lockstep_issuer.sv
// alu_lockstep_issuer: drives one command to a primary and a shadow ALU in lockstep,
// returns the primary result and flags any divergence between the two.
module alu_lockstep_issuer #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic [2:0]       cmd_opc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_opc,
    input  logic [WIDTH-1:0] alu_w_b,
    input  logic             alu_z_b,
    input  logic             alu_n_b,
    input  logic [WIDTH-1:0] alu_w_s,
    input  logic             alu_z_s,
    input  logic             alu_n_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_w,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             rsp_mismatch,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [2:0]       alu_opc_q, alu_opc_d;
    logic [WIDTH-1:0] rsp_w_q, rsp_w_d;
    logic             rsp_z_q, rsp_z_d, rsp_n_q, rsp_n_d, rsp_mm_q, rsp_mm_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             accept, done, mismatch;

    assign accept   = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;
    assign done     = (state_q == S_SETTLE) && (cnt_q == 4'd0);
    assign mismatch = (alu_w_b != alu_w_s) | (alu_z_b != alu_z_s) | (alu_n_b != alu_n_s);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_opc_d   = alu_opc_q;
        rsp_w_d     = rsp_w_q;
        rsp_z_d     = rsp_z_q;
        rsp_n_d     = rsp_n_q;
        rsp_mm_d    = rsp_mm_q;
        err_d       = err_q;
        if (state_q == S_IDLE) begin
            // cmd_ready comes up one edge after reset release, then drops on accept
            cmd_ready_d = ~accept;
            if (accept) begin
                alu_a_d   = cmd_a;
                alu_b_d   = cmd_b;
                alu_cin_d = cmd_cin;
                alu_opc_d = cmd_opc;
                cnt_d     = CNT_INIT;
                state_d   = S_SETTLE;
            end
        end else if (state_q == S_SETTLE) begin
            cnt_d = done ? cnt_q : cnt_q - 4'd1;
            if (done) begin
                rsp_w_d     = alu_w_b;
                rsp_z_d     = alu_z_b;
                rsp_n_d     = alu_n_b;
                rsp_mm_d    = mismatch;
                err_d       = (mismatch && !(&err_q)) ? err_q + 1'b1 : err_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_opc_q   <= 3'd0;
            rsp_w_q     <= '0;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
            rsp_mm_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_opc_q   <= alu_opc_d;
            rsp_w_q     <= rsp_w_d;
            rsp_z_q     <= rsp_z_d;
            rsp_n_q     <= rsp_n_d;
            rsp_mm_q    <= rsp_mm_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_cin      = alu_cin_q;
    assign alu_opc      = alu_opc_q;
    assign rsp_w        = rsp_w_q;
    assign rsp_z        = rsp_z_q;
    assign rsp_n        = rsp_n_q;
    assign rsp_mismatch = rsp_mm_q;
    assign err_count    = err_q;
endmodule

// File: tb/tb_alu_lockstep_issuer.sv
// tb_alu_lockstep_issuer: directed checks of handshake, latency, lockstep compare and saturation.
module tb_alu_lockstep_issuer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic        cmd_cin = 1'b0;
    logic [2:0]  cmd_opc = 3'd0;
    logic [15:0] alu_a, alu_b;
    logic        alu_cin;
    logic [2:0]  alu_opc;
    logic [15:0] alu_w_b, alu_w_s;
    logic        alu_z_b, alu_n_b, alu_z_s, alu_n_s;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [15:0] rsp_w;
    logic        rsp_z, rsp_n, rsp_mismatch;
    logic [1:0]  err_count;
    logic        mm_z = 1'b0, mm_w = 1'b0;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    // primary ALU model; the shadow copies it unless a divergence is injected
    assign alu_w_b = (alu_opc == 3'd0) ? alu_a + alu_b + {15'd0, alu_cin} : alu_a & alu_b;
    assign alu_z_b = (alu_w_b == 16'd0);
    assign alu_n_b = alu_w_b[15];
    assign alu_w_s = alu_w_b ^ {15'd0, mm_w};
    assign alu_z_s = alu_z_b ^ mm_z;
    assign alu_n_s = alu_n_b;

    alu_lockstep_issuer #(.WIDTH(16), .SETTLE(2), .ERR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_opc(cmd_opc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opc(alu_opc),
        .alu_w_b(alu_w_b), .alu_z_b(alu_z_b), .alu_n_b(alu_n_b),
        .alu_w_s(alu_w_s), .alu_z_s(alu_z_s), .alu_n_s(alu_n_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_w(rsp_w), .rsp_z(rsp_z), .rsp_n(rsp_n),
        .rsp_mismatch(rsp_mismatch), .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd2);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_opc = 3'd0; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_pre", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_post", 32'(cmd_ready), 32'd0);
        chk("alu_a", 32'(alu_a), 32'(a));
        chk("alu_b", 32'(alu_b), 32'(b));
        wait_rsp();
    endtask

    task automatic rsp_chk(input logic [15:0] w, input logic z, input logic n, input logic mm, input logic [1:0] err);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_w", 32'(rsp_w), 32'(w));
        chk("rsp_z", 32'(rsp_z), 32'(z));
        chk("rsp_n", 32'(rsp_n), 32'(n));
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'(mm));
        chk("err_count", 32'(err_count), 32'(err));
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("drain_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_rsp_w", 32'(rsp_w), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        chk("rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        chk("rel_cmd_ready_high", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        do_reset();
        rsp_ready = 1'b1;
        tick(); tick();
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        issue(16'h7FFF, 16'h0001, 1'b0);
        rsp_chk(16'h8000, 1'b0, 1'b1, 1'b0, 2'd0);
        drain();

        issue(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rsp_chk(16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        // a command offered during the response handshake is taken one edge later
        cmd_a = 16'h1234; cmd_b = 16'h0100; cmd_cin = 1'b1; cmd_valid = 1'b1;
        drain();
        chk("overlap_alu_a_old", 32'(alu_a), 32'h0000FFFF);
        chk("overlap_rsp_w_kept", 32'(rsp_w), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("overlap_accept", 32'(cmd_ready), 32'd0);
        chk("overlap_alu_a_new", 32'(alu_a), 32'h00001234);
        wait_rsp();
        rsp_chk(16'h1335, 1'b0, 1'b0, 1'b0, 2'd0);
        drain();

        mm_z = 1'b1;
        issue(16'd5, 16'd6, 1'b0);
        rsp_chk(16'd11, 1'b0, 1'b0, 1'b1, 2'd1);
        drain();
        mm_z = 1'b0;
        issue(16'h8000, 16'h8000, 1'b1);
        rsp_chk(16'h0001, 1'b0, 1'b0, 1'b0, 2'd1);
        drain();
        chk("alu_a_hold", 32'(alu_a), 32'h00008000);

        do_reset();
        mm_w = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(16'(i + 1), 16'(i + 1), 1'b0);
            rsp_chk(16'(2 * (i + 1)), 1'b0, 1'b0, 1'b1, (i >= 2) ? 2'd3 : 2'(i + 1));
            drain();
        end
        mm_w = 1'b0;

        cmd_a = 16'hABCD; cmd_b = 16'h1111; cmd_cin = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("mid_accept_alu_a", 32'(alu_a), 32'h0000ABCD);
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("mid_alu_a_zero", 32'(alu_a), 32'd0);
        issue(16'd3, 16'd4, 1'b0);
        rsp_chk(16'd7, 1'b0, 1'b0, 1'b0, 2'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
